ahb_apb_slave_if: RTL and testbench

Parametrised AHB-Lite slave front end for the AHB-to-APB bridge. Accepts pipelined AHB transfers, decodes the address into one of NUM_SEL equally sized APB regions, and issues one request per transfer to the APB-side controller over a valid/done handshake. It stretches the AHB data phase with wait states until the APB side completes, and returns read data or a two-cycle ERROR response (unmapped address or APB slave error).

---
 rtl/ahb_apb_pkg.sv | 30 +++
 rtl/apb_region_decode.sv | 43 ++++
 rtl/ahb_apb_slave_if.sv | 125 ++++++++++++
 tb/tb_ahb_apb_slave_if.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_pkg
// Description : Shared constants and types for the AHB-to-APB bridge:
//               HTRANS / HRESP encodings and the AHB slave front-end FSM
//               state encoding (also consumed by the APB controller's
//               debug view).
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_REQ  = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } ahb_state_e;

endpackage : ahb_apb_pkg
`default_nettype wire

// File: rtl/apb_region_decode.sv
`default_nettype none
// ============================================================================
// Module      : apb_region_decode
// Description : Combinational address decoder. Splits the address space
//               above BASE_ADDR into NUM_SEL equally sized regions of
//               2^REGION_BITS bytes and returns a hit flag plus a one-hot
//               region select (all zero on a miss).
// Ports       : haddr - address to decode
//               hit   - address falls inside one of the regions
//               sel   - one-hot region select
// Revision    : 1.0 - initial release
// ============================================================================
module apb_region_decode #(
    parameter int                ADDR_W      = 32,
    parameter int                NUM_SEL     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                REGION_BITS = 26
) (
    input  logic [ADDR_W-1:0]  haddr,
    output logic               hit,
    output logic [NUM_SEL-1:0] sel
);

    localparam int UW = ADDR_W - REGION_BITS;   // region index field width
    localparam int CW = UW + 5;                 // wide enough to hold NUM_SEL (<=16)

    localparam logic [UW-1:0] c_base_hi = BASE_ADDR[ADDR_W-1:REGION_BITS];

    logic [UW-1:0] w_idx;

    // Below BASE_ADDR the subtraction wraps; the >= test rejects those.
    assign w_idx = haddr[ADDR_W-1:REGION_BITS] - c_base_hi;
    assign hit   = (haddr >= BASE_ADDR) && (CW'(w_idx) < CW'(NUM_SEL));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEL; gi++) begin : g_sel
            assign sel[gi] = hit && (CW'(w_idx) == CW'(gi));
        end
    endgenerate

endmodule : apb_region_decode
`default_nettype wire

// File: rtl/ahb_apb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_slave_if
// Description : AHB-Lite slave front end of the AHB-to-APB bridge. Accepts
//               pipelined transfers, decodes them into APB regions, hands one
//               request per transfer to the APB controller (valid/done) and
//               stretches the data phase until completion. Unmapped
//               addresses and APB slave errors return a two-cycle ERROR.
// Ports       : hclk, hresetn (sync, active-low)
//               AHB  : hreadyin, htrans, hwrite, haddr, hwdata,
//                      hrdata, hreadyout, hresp
//               APB  : req_valid, req_write, req_addr, req_wdata, req_sel,
//                      req_done, req_err, req_rdata
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_apb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SEL     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                REGION_BITS = 26
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               hreadyin,
    input  logic [1:0]         htrans,
    input  logic               hwrite,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [DATA_W-1:0]  hwdata,
    output logic [DATA_W-1:0]  hrdata,
    output logic               hreadyout,
    output logic [1:0]         hresp,
    output logic               req_valid,
    output logic               req_write,
    output logic [ADDR_W-1:0]  req_addr,
    output logic [DATA_W-1:0]  req_wdata,
    output logic [NUM_SEL-1:0] req_sel,
    input  logic               req_done,
    input  logic               req_err,
    input  logic [DATA_W-1:0]  req_rdata
);

    ahb_state_e         r_state;
    ahb_state_e         w_state_nxt;
    logic [DATA_W-1:0]  r_hrdata;
    logic               r_req_write;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [DATA_W-1:0]  r_req_wdata;
    logic [NUM_SEL-1:0] r_req_sel;

    logic               w_hit;
    logic [NUM_SEL-1:0] w_sel;
    logic               w_open;
    logic               w_accept;

    apb_region_decode #(
        .ADDR_W      (ADDR_W),
        .NUM_SEL     (NUM_SEL),
        .BASE_ADDR   (BASE_ADDR),
        .REGION_BITS (REGION_BITS)
    ) u_decode (
        .haddr (haddr),
        .hit   (w_hit),
        .sel   (w_sel)
    );

    // RESP and ERR2 are the last data-phase cycle of the previous transfer
    // with hreadyout high, so the next address phase may overlap them.
    assign w_open   = (r_state == ST_IDLE) || (r_state == ST_RESP) || (r_state == ST_ERR2);
    assign w_accept = hreadyin && w_open &&
                      ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RESP, ST_ERR2: begin
                if (w_accept) w_state_nxt = w_hit ? ST_DATA : ST_ERR1;
                else          w_state_nxt = ST_IDLE;
            end
            ST_DATA: w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (req_done) w_state_nxt = req_err ? ST_ERR1 : ST_RESP;
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_state     <= ST_IDLE;
            r_hrdata    <= '0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req_write <= hwrite;
                r_req_addr  <= haddr;
                r_req_sel   <= w_sel;   // zero on a miss
            end
            if ((r_state == ST_DATA) && r_req_write) begin
                r_req_wdata <= hwdata;
            end
            if ((r_state == ST_REQ) && req_done && !req_err && !r_req_write) begin
                r_hrdata <= req_rdata;
            end
        end
    end

    assign hrdata    = r_hrdata;
    assign hreadyout = (r_state == ST_IDLE) || (r_state == ST_RESP) || (r_state == ST_ERR2);
    assign hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign req_valid = (r_state == ST_REQ);
    assign req_write = r_req_write;
    assign req_addr  = r_req_addr;
    assign req_wdata = r_req_wdata;
    assign req_sel   = r_req_sel;

endmodule : ahb_apb_slave_if
`default_nettype wire

// File: tb/tb_ahb_apb_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_apb_slave_if
// Description : Self-checking bench for ahb_apb_slave_if with the default
//               parameters (3 regions of 64 MB from 0x8000_0000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_apb_slave_if;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_sel;
    logic        req_done;
    logic        req_err;
    logic [31:0] req_rdata;

    int total = 0;
    int bad   = 0;

    always #5 hclk = ~hclk;

    ahb_apb_slave_if dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hreadyin  (hreadyin),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          k;         // REQ cycle in which req_done fires
        logic        err;
        logic        hit;
        logic [2:0]  sel;
        int          waits;     // data-phase cycles with hreadyout=0
        logic [1:0]  resp;      // hresp in the final data-phase cycle
        logic [31:0] hrdata;    // hrdata when hreadyout rises
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_addr(input logic [1:0] tr, input logic wr, input logic [31:0] a);
        hreadyin = 1'b1;
        htrans   = tr;
        hwrite   = wr;
        haddr    = a;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int          waits;
        int          reqc;
        logic        saw_valid;
        logic [1:0]  last_resp;
        drive_addr(2'b10, v.write, v.addr);
        tick();
        htrans    = 2'b00;
        hwdata    = v.wdata;
        waits     = 0;
        reqc      = 0;
        saw_valid = 1'b0;
        last_resp = 2'b00;
        while (hreadyout == 1'b0 && waits < 20) begin
            waits++;
            last_resp = hresp;
            if (req_valid) begin
                saw_valid = 1'b1;
                reqc++;
                if (reqc == 1) begin
                    chk($sformatf("v%0d req_sel", n),   {29'd0, req_sel},   {29'd0, v.sel});
                    chk($sformatf("v%0d req_addr", n),  req_addr,           v.addr);
                    chk($sformatf("v%0d req_write", n), {31'd0, req_write}, {31'd0, v.write});
                    if (v.write) chk($sformatf("v%0d req_wdata", n), req_wdata, v.wdata);
                end
                if (reqc == v.k) begin
                    req_done  = 1'b1;
                    req_err   = v.err;
                    req_rdata = v.rdata;
                end
            end
            tick();
            req_done  = 1'b0;
            req_err   = 1'b0;
            req_rdata = 32'h0;
        end
        chk($sformatf("v%0d waits", n),      waits,              v.waits);
        chk($sformatf("v%0d req_valid", n),  {31'd0, saw_valid}, {31'd0, v.hit});
        chk($sformatf("v%0d wait hresp", n), {30'd0, last_resp}, {30'd0, v.resp});
        chk($sformatf("v%0d end hresp", n),  {30'd0, hresp},     {30'd0, v.resp});
        chk($sformatf("v%0d hrdata", n),     hrdata,             v.hrdata);
        tick();
        chk($sformatf("v%0d idle hresp", n), {30'd0, hresp},     32'd0);
        chk($sformatf("v%0d idle hready", n), {31'd0, hreadyout}, 32'd1);
    endtask

    initial begin
        //         wr    addr           wdata          rdata          k  err hit sel     waits resp   hrdata
        vecs[0] = '{1'b1, 32'h8400_0010, 32'hDEAD_BEEF, 32'h0,         1, 1'b0, 1'b1, 3'b010, 2, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h8800_0004, 32'h0,         32'h1234_5678, 3, 1'b0, 1'b1, 3'b100, 4, 2'b00, 32'h1234_5678};
        vecs[2] = '{1'b0, 32'h8C00_0000, 32'h0,         32'hFFFF_FFFF, 1, 1'b0, 1'b0, 3'b000, 1, 2'b01, 32'h1234_5678};
        vecs[3] = '{1'b1, 32'h7FFF_FFFC, 32'h5555_AAAA, 32'h0,         1, 1'b0, 1'b0, 3'b000, 1, 2'b01, 32'h1234_5678};
        vecs[4] = '{1'b0, 32'h8000_0100, 32'h0,         32'hBAD0_BAD0, 1, 1'b1, 1'b1, 3'b001, 3, 2'b01, 32'h1234_5678};
        vecs[5] = '{1'b0, 32'h8000_0008, 32'h0,         32'hA5A5_0F0F, 2, 1'b0, 1'b1, 3'b001, 3, 2'b00, 32'hA5A5_0F0F};
        vecs[6] = '{1'b1, 32'h8BFF_FFFC, 32'h0BAD_F00D, 32'h0,         2, 1'b0, 1'b1, 3'b100, 3, 2'b00, 32'hA5A5_0F0F};

        hresetn   = 1'b0;
        hreadyin  = 1'b1;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        haddr     = 32'h0;
        hwdata    = 32'h0;
        req_done  = 1'b0;
        req_err   = 1'b0;
        req_rdata = 32'h0;
        tick();
        tick();
        hresetn = 1'b1;

        // reset state
        chk("rst hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("rst hresp",     {30'd0, hresp},     32'd0);
        chk("rst hrdata",    hrdata,             32'd0);
        chk("rst req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst req_sel",   {29'd0, req_sel},   32'd0);
        chk("rst req_addr",  req_addr,           32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // back-to-back: write, then NONSEQ read in its RESP, then SEQ read
        drive_addr(2'b10, 1'b1, 32'h8400_0000);
        tick();                                     // DATA
        htrans = 2'b00;
        hwdata = 32'h1111_1111;
        tick();                                     // REQ
        chk("b2b w valid", {31'd0, req_valid}, 32'd1);
        req_done = 1'b1;
        tick();                                     // RESP
        req_done = 1'b0;
        chk("b2b w resp ready", {31'd0, hreadyout}, 32'd1);
        chk("b2b w wdata", req_wdata, 32'h1111_1111);
        drive_addr(2'b10, 1'b0, 32'h8000_0000);
        tick();                                     // DATA
        htrans = 2'b00;
        chk("b2b r1 data ready", {31'd0, hreadyout}, 32'd0);
        chk("b2b r1 data valid", {31'd0, req_valid}, 32'd0);
        tick();                                     // REQ
        chk("b2b r1 valid", {31'd0, req_valid}, 32'd1);
        chk("b2b r1 addr",  req_addr,           32'h8000_0000);
        chk("b2b r1 sel",   {29'd0, req_sel},   32'd1);
        chk("b2b r1 write", {31'd0, req_write}, 32'd0);
        req_done  = 1'b1;
        req_rdata = 32'hCAFE_0001;
        tick();                                     // RESP
        req_done  = 1'b0;
        req_rdata = 32'h0;
        chk("b2b r1 hrdata", hrdata, 32'hCAFE_0001);
        chk("b2b r1 ready",  {31'd0, hreadyout}, 32'd1);
        drive_addr(2'b11, 1'b0, 32'h8000_0004);
        tick();                                     // DATA
        htrans = 2'b01;
        chk("b2b r2 data ready", {31'd0, hreadyout}, 32'd0);
        tick();                                     // REQ
        chk("b2b r2 addr", req_addr, 32'h8000_0004);
        req_done  = 1'b1;
        req_rdata = 32'hCAFE_0002;
        tick();                                     // RESP
        req_done  = 1'b0;
        req_rdata = 32'h0;
        chk("b2b r2 hrdata", hrdata, 32'hCAFE_0002);

        // IDLE / BUSY / unready NONSEQ: zero-wait OKAY, no request
        htrans = 2'b01;
        tick();
        chk("busy ready", {31'd0, hreadyout}, 32'd1);
        chk("busy valid", {31'd0, req_valid}, 32'd0);
        htrans = 2'b00;
        tick();
        chk("idle hresp", {30'd0, hresp}, 32'd0);
        drive_addr(2'b10, 1'b0, 32'h8000_0000);
        hreadyin = 1'b0;
        tick();
        chk("noready ready", {31'd0, hreadyout}, 32'd1);
        hreadyin = 1'b1;
        htrans   = 2'b00;
        tick();
        chk("noready valid", {31'd0, req_valid}, 32'd0);

        // back-to-back error then mapped transfer accepted in ERR2
        drive_addr(2'b10, 1'b0, 32'h9000_0000);
        tick();                                     // ERR1
        htrans = 2'b00;
        chk("err1 resp", {30'd0, hresp}, 32'd1);
        tick();                                     // ERR2
        chk("err2 ready", {31'd0, hreadyout}, 32'd1);
        drive_addr(2'b10, 1'b1, 32'h8400_0020);
        tick();                                     // DATA
        htrans = 2'b00;
        hwdata = 32'h2222_2222;
        chk("err2 b2b data ready", {31'd0, hreadyout}, 32'd0);
        chk("err2 b2b data resp",  {30'd0, hresp},     32'd0);
        tick();                                     // REQ

        // reset during REQ, then a late req_done
        chk("mid valid", {31'd0, req_valid}, 32'd1);
        hresetn = 1'b0;
        tick();
        hresetn  = 1'b1;
        chk("mrst valid",  {31'd0, req_valid}, 32'd0);
        chk("mrst ready",  {31'd0, hreadyout}, 32'd1);
        chk("mrst hresp",  {30'd0, hresp},     32'd0);
        chk("mrst hrdata", hrdata,             32'd0);
        chk("mrst addr",   req_addr,           32'd0);
        chk("mrst wdata",  req_wdata,          32'd0);
        chk("mrst sel",    {29'd0, req_sel},   32'd0);
        chk("mrst write",  {31'd0, req_write}, 32'd0);
        req_done  = 1'b1;
        req_rdata = 32'h7777_7777;
        tick();
        req_done  = 1'b0;
        chk("late valid",  {31'd0, req_valid}, 32'd0);
        chk("late ready",  {31'd0, hreadyout}, 32'd1);
        chk("late hrdata", hrdata,             32'd0);
        chk("late hresp",  {30'd0, hresp},     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ahb_apb_slave_if
`default_nettype wire
